// File: rtl/data_ram_port.sv
// rtl/data_ram_port.sv - single-outstanding load/store requester for the data RAM
// Strobes the RAM for one cycle, then waits (bounded) for dataReady on loads.
module data_ram_port #(
   parameter int width   = 8,
   parameter int length  = 8,
   parameter int timeout = 4
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              reqValid,
   output logic              reqReady,
   input  logic              reqWrite,
   input  logic              reqIndirect,
   input  logic [length-1:0] reqAddr,
   input  logic [width-1:0]  reqData,
   output logic              respValid,
   output logic [width-1:0]  respData,
   output logic              respError,
   output logic              ramReadEnable,
   output logic              ramWriteEnable,
   output logic              ramIndirect,
   output logic [length-1:0] ramReadAddr,
   output logic [length-1:0] ramWriteAddr,
   output logic [width-1:0]  ramWriteData,
   input  logic              ramDataReady,
   input  logic [width-1:0]  ramReadData
);

   localparam int CW = (timeout > 1) ? $clog2(timeout) : 1;

   typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT, RESP} state_t;

   state_t            r_state;
   logic [CW-1:0]     r_count;
   logic              r_read_en;
   logic              r_write_en;
   logic              r_indirect;
   logic              r_resp_valid;
   logic              r_resp_error;
   logic [width-1:0]  r_resp_data;
   logic [length-1:0] r_addr;
   logic [width-1:0]  r_wdata;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_state      <= IDLE;
         r_count      <= '0;
         r_read_en    <= 1'b0;
         r_write_en   <= 1'b0;
         r_indirect   <= 1'b0;
         r_resp_valid <= 1'b0;
         r_resp_error <= 1'b0;
         r_resp_data  <= '0;
         r_addr       <= '0;
         r_wdata      <= '0;
      end else begin
         // strobes default low so each one lasts exactly the cycle it was set for
         r_read_en    <= 1'b0;
         r_write_en   <= 1'b0;
         r_indirect   <= 1'b0;
         r_resp_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (reqValid) begin
                  r_addr  <= reqAddr;
                  r_wdata <= reqData;
                  if (reqWrite) begin
                     r_state    <= WRITE;
                     r_write_en <= 1'b1;
                  end else begin
                     r_state    <= READ;
                     r_read_en  <= 1'b1;
                     r_indirect <= reqIndirect;
                  end
               end
            end
            WRITE: begin
               r_state      <= RESP;
               r_resp_valid <= 1'b1;
               r_resp_error <= 1'b0;
            end
            READ: begin
               r_count <= '0;
               r_state <= WAIT;
            end
            WAIT: begin
               // ready takes priority over a timeout expiring on the same edge
               if (ramDataReady) begin
                  r_resp_data  <= ramReadData;
                  r_resp_error <= 1'b0;
                  r_resp_valid <= 1'b1;
                  r_state      <= RESP;
               end else if (r_count == CW'(timeout - 1)) begin
                  r_resp_data  <= '0;
                  r_resp_error <= 1'b1;
                  r_resp_valid <= 1'b1;
                  r_state      <= RESP;
               end else begin
                  r_count <= r_count + CW'(1);
               end
            end
            RESP: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign reqReady       = (r_state == IDLE);
   assign respValid      = r_resp_valid;
   assign respData       = r_resp_data;
   assign respError      = r_resp_error;
   assign ramReadEnable  = r_read_en;
   assign ramWriteEnable = r_write_en;
   assign ramIndirect    = r_indirect;
   assign ramReadAddr    = r_addr;
   assign ramWriteAddr   = r_addr;
   assign ramWriteData   = r_wdata;

endmodule

// File: tb/tb_data_ram_port.sv
// tb/tb_data_ram_port.sv - directed plus random requests against a reference memory model
module tb_data_ram_port;

   localparam int W  = 8;
   localparam int L  = 8;
   localparam int TO = 4;

   logic         clk;
   logic         clr;
   logic         reqValid;
   logic         reqReady;
   logic         reqWrite;
   logic         reqIndirect;
   logic [L-1:0] reqAddr;
   logic [W-1:0] reqData;
   logic         respValid;
   logic [W-1:0] respData;
   logic         respError;
   logic         ramReadEnable;
   logic         ramWriteEnable;
   logic         ramIndirect;
   logic [L-1:0] ramReadAddr;
   logic [L-1:0] ramWriteAddr;
   logic [W-1:0] ramWriteData;
   logic         ramDataReady;
   logic [W-1:0] ramReadData;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] ram_mem [256];
   logic [7:0] ref_mem [256];
   int         ram_delay = 1;
   bit         ram_stale = 0;
   int         ram_cnt   = 0;
   logic [7:0] ram_a     = 0;
   bit         ram_ind   = 0;
   logic [7:0] exp_resp_data = 0;

   data_ram_port #(.width(W), .length(L), .timeout(TO)) dut (
      .clk(clk), .clr(clr),
      .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
      .reqIndirect(reqIndirect), .reqAddr(reqAddr), .reqData(reqData),
      .respValid(respValid), .respData(respData), .respError(respError),
      .ramReadEnable(ramReadEnable), .ramWriteEnable(ramWriteEnable),
      .ramIndirect(ramIndirect), .ramReadAddr(ramReadAddr),
      .ramWriteAddr(ramWriteAddr), .ramWriteData(ramWriteData),
      .ramDataReady(ramDataReady), .ramReadData(ramReadData)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   // RAM: answers ram_delay cycles after a read strobe (0 = never), garbage data otherwise
   always @(negedge clk) begin
      if (ramWriteEnable) ram_mem[ramWriteAddr] = ramWriteData;
      if (ramReadEnable) begin
         ram_cnt      = ram_delay;
         ram_a        = ramReadAddr;
         ram_ind      = ramIndirect;
         ramDataReady = ram_stale;
         ramReadData  = 8'($urandom);
      end else if (ram_cnt > 0) begin
         ram_cnt--;
         if (ram_cnt == 0) begin
            ramDataReady = 1'b1;
            ramReadData  = ram_ind ? ram_mem[ram_mem[ram_a]] : ram_mem[ram_a];
         end else begin
            ramDataReady = ram_stale;
            ramReadData  = 8'($urandom);
         end
      end else begin
         ramDataReady = ram_stale;
         ramReadData  = 8'($urandom);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Issue one request (starting at a negedge) and check every cycle until reqReady returns.
   task automatic run_req(input bit w, input bit ind, input logic [7:0] a, input logic [7:0] d,
                          input bit chain, input bit cw, input bit cind,
                          input logic [7:0] ca, input logic [7:0] cd);
      int         n;
      int         lat;
      int         done;
      bit         exp_err;
      logic [7:0] exp_data;
      reqWrite = w; reqIndirect = ind; reqAddr = a; reqData = d; reqValid = 1;
      n = 0;
      while (!reqReady && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("accept_ready", reqReady, 1);
      if (w) begin
         lat = 2; exp_err = 0; exp_data = exp_resp_data; ref_mem[a] = d;
      end else if (ram_delay != 0 && ram_delay <= TO) begin
         lat = ram_delay + 2; exp_err = 0;
         exp_data = ind ? ref_mem[ref_mem[a]] : ref_mem[a];
      end else begin
         lat = TO + 2; exp_err = 1; exp_data = 0;
      end
      done = lat + 1;
      @(posedge clk);
      for (int k = 1; k <= done; k++) begin
         @(negedge clk);
         if (k == 1) begin
            if (chain) begin
               reqWrite = cw; reqIndirect = cind; reqAddr = ca; reqData = cd;
            end else begin
               reqValid = 0;
            end
         end
         check("req_ready", reqReady, k == done);
         check("wr_en", ramWriteEnable, w && k == 1);
         check("rd_en", ramReadEnable, !w && k == 1);
         check("indirect", ramIndirect, !w && ind && k == 1);
         check("resp_valid", respValid, k == lat);
         if (k == 1) begin
            check("wr_addr", ramWriteAddr, a);
            check("rd_addr", ramReadAddr, a);
            check("wr_data", ramWriteData, d);
         end
         if (k == lat) begin
            check("resp_error", respError, exp_err);
            check("resp_data", respData, exp_data);
         end
      end
      exp_resp_data = exp_data;
   endtask

   initial begin
      clr = 0; reqValid = 0; reqWrite = 0; reqIndirect = 0; reqAddr = 0; reqData = 0;
      ramDataReady = 0; ramReadData = 0;
      for (int i = 0; i < 256; i++) begin
         ram_mem[i] = 8'($urandom);
         ref_mem[i] = ram_mem[i];
      end
      repeat (2) @(negedge clk);
      check("rst_req_ready", reqReady, 1);
      check("rst_rd_en", ramReadEnable, 0);
      check("rst_wr_en", ramWriteEnable, 0);
      check("rst_indirect", ramIndirect, 0);
      check("rst_resp_valid", respValid, 0);
      check("rst_resp_error", respError, 0);
      check("rst_resp_data", respData, 0);
      check("rst_rd_addr", ramReadAddr, 0);
      check("rst_wr_addr", ramWriteAddr, 0);
      check("rst_wr_data", ramWriteData, 0);
      clr = 1;
      @(negedge clk);

      ram_delay = 1;
      run_req(1, 0, 8'h10, 8'hA5, 0, 0, 0, 0, 0);
      run_req(0, 0, 8'h10, 8'h00, 0, 0, 0, 0, 0);
      run_req(1, 1, 8'h20, 8'h30, 0, 0, 0, 0, 0);
      run_req(1, 0, 8'h30, 8'h7C, 0, 0, 0, 0, 0);
      run_req(0, 1, 8'h20, 8'h00, 0, 0, 0, 0, 0);
      check("indirect_value", exp_resp_data, 8'h7C);

      ram_delay = 0;
      run_req(0, 0, 8'h10, 8'h00, 0, 0, 0, 0, 0);
      ram_delay = TO;
      run_req(0, 0, 8'h30, 8'h00, 0, 0, 0, 0, 0);
      ram_delay = 1;

      run_req(1, 0, 8'h40, 8'h5A, 1, 0, 0, 8'h40, 8'h00);
      run_req(0, 0, 8'h40, 8'h00, 0, 0, 0, 0, 0);
      check("b2b_load_value", respData, 8'h5A);

      ram_stale = 1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("stale_resp_valid", respValid, 0);
         check("stale_req_ready", reqReady, 1);
      end
      ram_stale = 0;
      @(negedge clk);

      ram_delay = 0;
      reqWrite = 0; reqIndirect = 0; reqAddr = 8'h55; reqValid = 1;
      @(posedge clk);
      @(negedge clk);
      reqValid = 0;
      check("pre_rst_rd_en", ramReadEnable, 1);
      @(negedge clk);
      #2 clr = 0;
      #1;
      check("arst_req_ready", reqReady, 1);
      check("arst_rd_en", ramReadEnable, 0);
      check("arst_wr_en", ramWriteEnable, 0);
      check("arst_resp_valid", respValid, 0);
      check("arst_resp_data", respData, 0);
      check("arst_rd_addr", ramReadAddr, 0);
      check("arst_wr_data", ramWriteData, 0);
      @(negedge clk);
      clr = 1;
      exp_resp_data = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check("post_rst_resp_valid", respValid, 0);
         check("post_rst_req_ready", reqReady, 1);
      end
      ram_delay = 1;
      run_req(0, 0, 8'h10, 8'h00, 0, 0, 0, 0, 0);

      for (int i = 0; i < 24; i++) begin
         ram_delay = $urandom_range(0, 5);
         run_req(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 0, 0, 0, 0, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/data_ram_port.md
# data_ram_port

Requester-side controller for the processor's data RAM. It accepts one load/store request at a time from the core over a valid/ready handshake. It drives the RAM's read/write enables, addresses, write data and indirect flag with one-cycle pulses, then waits for the RAM's `dataReady`. It returns read data or a completion pulse to the core, and flags an error if the RAM never answers within a bounded number of cycles.

## Interface
- `width`, 8, data word width; matches the RAM word width.
- `length`, 8, address width; matches the RAM address width.
- `timeout`, 4, maximum WAIT cycles for `ramDataReady`; must be ≥1.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `clr`  in  1  reset, asynchronous, active-low.
- `reqValid`  in  1  core presents a request.
- `reqReady`  out  1  block can accept a request; high only in IDLE.
- `reqWrite`  in  1  1 = store, 0 = load.
- `reqIndirect`  in  1  load uses indirect addressing (ignored for stores).
- `reqAddr`  in  `length`  request address.
- `reqData`  in  `width`  store data.
- `respValid`  out  1  one-cycle completion pulse.
- `respData`  out  `width`  load result; held until the next response.
- `respError`  out  1  qualifies `respValid`: load timed out.
- `ramReadEnable`  out  1  RAM read strobe.
- `ramWriteEnable`  out  1  RAM write strobe.
- `ramIndirect`  out  1  RAM indirect flag.
- `ramReadAddr`  out  `length`  RAM read address.
- `ramWriteAddr`  out  `length`  RAM write address.
- `ramWriteData`  out  `width`  RAM write data.
- `ramDataReady`  in  1  RAM read-complete flag.
- `ramReadData`  in  `width`  RAM read data.

## Operation
- States: IDLE, WRITE, READ, WAIT, RESP.
- **IDLE:** `reqReady`=1.
  - On `reqValid`=1, latch `reqWrite`, `reqIndirect`, `reqAddr` and `reqData`.
  - Go to WRITE if `reqWrite`=1, else READ.
- **WRITE:** `ramWriteEnable`=1 for exactly this one cycle, then go to RESP with `respError`=0.
- **READ:** `ramReadEnable`=1 and `ramIndirect`=latched indirect flag for exactly this one cycle. Clear the timeout counter, then go to WAIT.
- **WAIT:** both enables are 0.
  - If `ramDataReady`=1: capture `ramReadData` into `respData`, set `respError`=0, go to RESP.
  - Otherwise increment the counter. When it reaches `timeout`-1 without ready: set `respError`=1, set `respData`=0, go to RESP.
- **RESP:** `respValid`=1 for one cycle, then go to IDLE.
- Store responses leave `respData` unchanged.
- `ramReadAddr` and `ramWriteAddr` both carry the latched address; `ramWriteData` carries the latched store data. These hold their values between requests.
- The enables never assert together and are never high for more than one consecutive cycle. The RAM therefore drops `dataReady` on its own after each read.
- `ramDataReady` is ignored in every state except WAIT, including any stale assertion seen in IDLE.
- `ramIndirect` is 0 in every state except READ.
- Requests presented while `reqReady`=0 are not accepted. The core must hold `reqValid` and the request fields until it sees `reqReady`=1.

## Timing
- Reset (`clr`=0, asynchronous):
  - State goes to IDLE immediately.
  - `ramReadEnable`, `ramWriteEnable`, `ramIndirect`, `respValid` and `respError` go to 0.
  - `respData`, `ramReadAddr`, `ramWriteAddr` and `ramWriteData` go to 0.
  - `reqReady`=1, decoded from state.
- All outputs except `reqReady` are registered.
- Latency is counted from the edge E that accepts the request:
  - Store: `ramWriteEnable` high in cycle E+1; `respValid` high in cycle E+2; `reqReady` high again in cycle E+3.
  - Load, RAM answering on time: `ramReadEnable` high in cycle E+1; `ramDataReady` seen in cycle E+2; `respValid` high in cycle E+3; `reqReady` high again in cycle E+4.
  - Load timing out: `respValid` high `timeout`+2 cycles after E, with `respError`=1.
- Throughput: at most one request every 3 cycles (store) or 4 cycles (load).
- Reset asserted mid-operation: the in-flight request is dropped with no `respValid`, and enables fall the same instant.
- `ramDataReady` arriving in the same cycle the timeout expires: ready wins, `respError`=0.

## Test plan
- Reset, then store addr 0x10 data 0xA5 → `ramWriteEnable` high exactly 1 cycle with `ramWriteAddr`=0x10 and `ramWriteData`=0xA5; `respValid` 2 cycles after accept, `respError`=0.
- Load 0x10 from a RAM model returning 0xA5 one cycle after the strobe → `respData`=0xA5 with `respValid` at E+3, and `ramReadEnable` never high for 2 consecutive cycles.
- Indirect load: mem[0x20]=0x30, mem[0x30]=0x7C → `ramIndirect`=1 only during READ; `respData`=0x7C.
- RAM model never asserts ready, `timeout`=4 → `respValid` at E+6 with `respError`=1 and `respData`=0; `reqReady` returns to 1 the following cycle.
- Back-to-back: `reqValid` held high with a store then a load → second accept occurs at E+3; `ramWriteEnable` and `ramReadEnable` never overlap; both responses are correct.
- `clr` pulsed low during WAIT → enables and `respValid` go to 0 asynchronously, and no response is produced; the next load completes normally.
